regfile_zero: RTL and testbench
===============================

REGFILE_ZERO -- requirements
Module: regfile_zero

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of each register and data port.
REQ-002 The block SHALL have parameter SEL_WIDTH, default 5, giving the select width; register count = 2**SEL_WIDTH.
REQ-003 The parameters SHALL be declared in the order DATA_WIDTH, SEL_WIDTH so that positional override #(32,5) is valid.
REQ-004 clk  input  1  single clock; all register updates occur on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 we  input  1  write enable, sampled at the rising edge of clk.
REQ-007 wsel  input  SEL_WIDTH  write register select.
REQ-008 wdata  input  DATA_WIDTH  write data.
REQ-009 asel  input  SEL_WIDTH  read port A select.
REQ-010 adata  output  DATA_WIDTH  read port A data.
REQ-011 bsel  input  SEL_WIDTH  read port B select.
REQ-012 bdata  output  DATA_WIDTH  read port B data.

Function
REQ-013 The storage SHALL be 2**SEL_WIDTH registers of DATA_WIDTH bits each.
REQ-014 At a rising clk edge with rst high, we=1 and wsel!=0, register[wsel] SHALL take the value of wdata.
REQ-015 A write with wsel=0 SHALL be discarded; register 0 SHALL never hold a nonzero value.
REQ-016 When we=0, no register SHALL change.
REQ-017 Both read ports SHALL be combinational with zero-cycle latency: adata=register[asel] and bdata=register[bsel], with no clock involvement.
REQ-018 A select of 0 on either read port SHALL return all zeros, regardless of writes or configuration.
REQ-019 Both ports SHALL be readable simultaneously, including when both select the same register, and both SHALL return identical data.
REQ-020 In the default build, a read of the register being written in the same cycle SHALL return the pre-write value, and SHALL return the new value from the cycle after the edge.
REQ-021 Read outputs SHALL never be X or Z once reset has been applied.

Reset
REQ-022 When rst goes low, all registers SHALL clear to 0 immediately, without waiting for a clk edge, so adata and bdata read 0 at once.
REQ-023 While rst is low, writes SHALL be ignored regardless of we.
REQ-024 If rst is asserted mid-operation, any write in that cycle SHALL be lost.
REQ-025 On rst deassertion, the first write SHALL take effect at the first rising clk edge that has rst high.

Configuration
REQ-026 The macro REGFILE_ZERO_BYPASS_EN SHALL control write-through forwarding.
REQ-027 When REGFILE_ZERO_BYPASS_EN is defined, a read port SHALL return wdata combinationally when all of the following hold: rst is high, we=1, the read select equals wsel, and wsel!=0.
REQ-028 Under REQ-027, the forwarded value SHALL appear in the same cycle, before the clock edge.
REQ-029 When REGFILE_ZERO_BYPASS_EN is undefined, REQ-020 SHALL apply and no forwarding logic SHALL exist.
REQ-030 With or without REGFILE_ZERO_BYPASS_EN, select 0 SHALL read 0 and reset SHALL dominate.

Verification
REQ-031 Reset, then rst=0 with arbitrary asel/bsel -> adata=bdata=0; after rst=1, every register reads 0.
REQ-032 Write 0xDEADBEEF to reg 5, then asel=5, bsel=5 -> adata=bdata=0xDEADBEEF.
REQ-033 Write 0x12345678 with wsel=0, then asel=0 -> adata=0x00000000.
REQ-034 In the write cycle of 0xA5A5A5A5 to reg 7, read with asel=7:
  - without the macro -> old value, then 0xA5A5A5A5 after the edge;
  - with REGFILE_ZERO_BYPASS_EN -> 0xA5A5A5A5 immediately.
REQ-035 Write 0x11 to reg 31 and 0x22 to reg 1, then drop rst low between clock edges -> adata and bdata go to 0 before the next edge, and reg 31 and reg 1 read 0 afterward.
REQ-036 Drive we=1 with wsel=3, wdata=0xFF while rst=0 -> after rst=1, reg 3 reads 0.

Source files
------------

// File: rtl/regfile_zero_if.sv
// ----------------------------------------------------------------------------
// regfile_zero_if
// Bus bundle for the regfile_zero register file: one write port and two
// combinational read ports.
//
// Signals
//   we     write enable, sampled at the rising clock edge
//   wsel   write register select
//   wdata  write data
//   asel   read port A select
//   adata  read port A data
//   bsel   read port B select
//   bdata  read port B data
//
// Modports
//   master  drives selects, write enable and write data; receives read data
//   slave   the register file side
// ----------------------------------------------------------------------------
interface regfile_zero_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 5
);
    logic                  we;
    logic [SEL_WIDTH-1:0]  wsel;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SEL_WIDTH-1:0]  asel;
    logic [DATA_WIDTH-1:0] adata;
    logic [SEL_WIDTH-1:0]  bsel;
    logic [DATA_WIDTH-1:0] bdata;

    modport master (
        output we, wsel, wdata, asel, bsel,
        input  adata, bdata
    );

    modport slave (
        input  we, wsel, wdata, asel, bsel,
        output adata, bdata
    );
endinterface

// File: rtl/regfile_zero.sv
// ----------------------------------------------------------------------------
// regfile_zero
// 2**SEL_WIDTH x DATA_WIDTH register file with one synchronous write port and
// two combinational read ports. Register 0 is hard-wired to zero: writes to it
// are discarded and reads of it return zero.
//
// Ports
//   clk   clock; all register updates on its rising edge
//   rst   asynchronous, active-low reset; clears every register at once
//   bus   regfile_zero_if.slave (we, wsel, wdata, asel, adata, bsel, bdata)
//
// Configuration
//   REGFILE_ZERO_BYPASS_EN  when defined, a read port whose select matches an
//                           active write (rst high, we=1, wsel!=0) returns
//                           wdata in the same cycle. When undefined, a read
//                           of the register being written returns the old
//                           value until the edge, and no forwarding exists.
// ----------------------------------------------------------------------------
module regfile_zero #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 5
) (
    input  logic          clk,
    input  logic          rst,
    regfile_zero_if.slave bus
);
    localparam int NUM_REGS = 2 ** SEL_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // Next-state: only the selected nonzero register takes wdata.
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (bus.we && (bus.wsel != '0)) begin
            regs_d[bus.wsel] = bus.wdata;
        end
        // Entry 0 is a constant; synthesis removes its flops.
        regs_d[0] = '0;
    end

    // NOTE: this storage is reset like ordinary flops (not left to a RAM
    // macro) because an asynchronous clear of every entry is required; that
    // rules out mapping it onto reset-less memory.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value at the same instant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REGFILE_ZERO_BYPASS_EN
    // Forwarding is gated by rst so reset still dominates the read data.
    logic fwd_ok;
    assign fwd_ok = rst && bus.we && (bus.wsel != '0);
`endif

    always_comb begin
        bus.adata = '0;
        if (bus.asel != '0) begin
            bus.adata = regs_q[bus.asel];
`ifdef REGFILE_ZERO_BYPASS_EN
            if (fwd_ok && (bus.asel == bus.wsel)) begin
                bus.adata = bus.wdata;
            end
`endif
        end
    end

    always_comb begin
        bus.bdata = '0;
        if (bus.bsel != '0) begin
            bus.bdata = regs_q[bus.bsel];
`ifdef REGFILE_ZERO_BYPASS_EN
            if (fwd_ok && (bus.bsel == bus.wsel)) begin
                bus.bdata = bus.wdata;
            end
`endif
        end
    end
endmodule

// File: tb/tb_regfile_zero.sv
// ----------------------------------------------------------------------------
// tb_regfile_zero
// Directed self-checking bench for regfile_zero (default 32 x 32 build).
// Expected read data for the same-cycle write case depends on
// REGFILE_ZERO_BYPASS_EN, matching the build of the design.
// ----------------------------------------------------------------------------
module tb_regfile_zero;
    localparam int DW = 32;
    localparam int SW = 5;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_zero_if #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

    regfile_zero #(DW, SW) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write launched on the falling edge, committed at the next rising edge.
    task automatic do_write(input logic [SW-1:0] sel, input logic [DW-1:0] data);
        @(negedge clk);
        bus.we    = 1'b1;
        bus.wsel  = sel;
        bus.wdata = data;
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
    endtask

    task automatic read_ab(input logic [SW-1:0] a, input logic [SW-1:0] b);
        bus.asel = a;
        bus.bsel = b;
        #1;
    endtask

    initial begin
        bus.we    = 1'b0;
        bus.wsel  = '0;
        bus.wdata = '0;
        bus.asel  = 5'd5;
        bus.bsel  = 5'd9;
        rst       = 1'b1;
        #1 rst    = 1'b0;
        #1;
        check("reset_adata", bus.adata, 32'h0);
        check("reset_bdata", bus.bdata, 32'h0);

        // Writes attempted while reset is held must be ignored.
        @(negedge clk);
        bus.we    = 1'b1;
        bus.wsel  = 5'd3;
        bus.wdata = 32'hFF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.we = 1'b0;
        rst    = 1'b1;
        read_ab(5'd3, 5'd3);
        check("wr_in_reset_a", bus.adata, 32'h0);
        check("wr_in_reset_b", bus.bdata, 32'h0);
        for (int i = 0; i < 32; i++) begin
            read_ab(i[SW-1:0], 5'(31 - i));
            check($sformatf("post_reset_a%0d", i), bus.adata, 32'h0);
        end

        // Basic write, both ports reading the same register.
        do_write(5'd5, 32'hDEADBEEF);
        read_ab(5'd5, 5'd5);
        check("reg5_a", bus.adata, 32'hDEADBEEF);
        check("reg5_b", bus.bdata, 32'hDEADBEEF);

        // Write to register 0 is discarded.
        do_write(5'd0, 32'h12345678);
        read_ab(5'd0, 5'd5);
        check("reg0_a", bus.adata, 32'h0);
        check("reg0_keep5_b", bus.bdata, 32'hDEADBEEF);

        // Same-cycle read of the register being written.
        do_write(5'd7, 32'h00000001);
        @(negedge clk);
        bus.asel  = 5'd7;
        bus.bsel  = 5'd0;
        bus.we    = 1'b1;
        bus.wsel  = 5'd7;
        bus.wdata = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_ZERO_BYPASS_EN
        check("rd_during_wr", bus.adata, 32'hA5A5A5A5);
`else
        check("rd_during_wr", bus.adata, 32'h00000001);
`endif
        check("rd_during_wr_sel0", bus.bdata, 32'h0);
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        check("rd_after_wr", bus.adata, 32'hA5A5A5A5);

        // A write to register 0 never forwards.
        @(negedge clk);
        bus.asel  = 5'd0;
        bus.we    = 1'b1;
        bus.wsel  = 5'd0;
        bus.wdata = 32'hCAFEF00D;
        #1;
        check("sel0_no_fwd", bus.adata, 32'h0);
        @(posedge clk);
        #1;
        bus.we = 1'b0;

        // Distinct registers on the two ports, then mid-cycle async reset.
        do_write(5'd31, 32'h11);
        do_write(5'd1, 32'h22);
        read_ab(5'd31, 5'd1);
        check("reg31_a", bus.adata, 32'h11);
        check("reg1_b", bus.bdata, 32'h22);
        @(negedge clk);
        bus.we    = 1'b1;
        bus.wsel  = 5'd9;
        bus.wdata = 32'h99;
        #2 rst    = 1'b0;
        #1;
        check("async_rst_a", bus.adata, 32'h0);
        check("async_rst_b", bus.bdata, 32'h0);
        @(posedge clk);
        #1;
        read_ab(5'd9, 5'd31);
        check("rst_wr_lost9", bus.adata, 32'h0);
        @(negedge clk);
        bus.we = 1'b0;
        rst    = 1'b1;
        read_ab(5'd31, 5'd1);
        check("after_rst_31", bus.adata, 32'h0);
        check("after_rst_1", bus.bdata, 32'h0);
        read_ab(5'd9, 5'd5);
        check("after_rst_9", bus.adata, 32'h0);
        check("after_rst_5", bus.bdata, 32'h0);

        // First write after reset release lands at the first rising edge.
        do_write(5'd2, 32'h5);
        read_ab(5'd2, 5'd2);
        check("first_wr_after_rst", bus.adata, 32'h5);

        // we=0 leaves everything unchanged.
        @(negedge clk);
        bus.we    = 1'b0;
        bus.wsel  = 5'd2;
        bus.wdata = 32'h77;
        @(posedge clk);
        #1;
        check("hold_we0", bus.bdata, 32'h5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
